// File: rtl/prod_accum_pkg.sv
// prod_accum_pkg: shared state encoding and default sizing for the product accumulator
package prod_accum_pkg;
    typedef enum logic {ACC, HOLD} state_t;
    localparam int PW_DEF = 8;
    localparam int N_TERMS_DEF = 4;
    localparam int CNT_W = $clog2(N_TERMS_DEF);
endpackage

// File: rtl/prod_accum_ctrl.sv
// prod_accum_ctrl: collect/hold FSM and term counter for prod_accum
module prod_accum_ctrl
    import prod_accum_pkg::*;
#(
    parameter int N_TERMS = N_TERMS_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic in_valid,
    input  logic out_ready,
    output logic in_ready,
    output logic out_valid,
    output logic last_term,
    output logic load_out,
    output logic clear_acc
);
    localparam int CW = $clog2(N_TERMS);
    state_t state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic accept;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACC;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end
    always_comb begin
        in_ready  = state == ACC;
        out_valid = state == HOLD;
        accept    = in_valid & in_ready & ~clr;
        last_term = cnt == CW'(N_TERMS - 1);
        clear_acc = cnt == '0;
        load_out  = accept & last_term;
        state_nxt = state;
        cnt_nxt   = cnt;
        if (clr) begin
            state_nxt = ACC;
            cnt_nxt   = '0;
        end else if (accept) begin
            state_nxt = last_term ? HOLD : ACC;
            cnt_nxt   = last_term ? '0 : cnt + CW'(1);
        end else if (out_valid && out_ready) begin
            state_nxt = ACC;
        end
    end
endmodule

// File: rtl/prod_accum.sv
// prod_accum: sums N_TERMS handshaked products into one held result; ACC_SAT_EN selects saturating adds
module prod_accum
    import prod_accum_pkg::*;
#(
    parameter int PW      = PW_DEF,
    parameter int N_TERMS = N_TERMS_DEF,
    parameter int AW      = PW + $clog2(N_TERMS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_prod,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_sum,
    output logic          out_ovf
);
    logic          last_term, load_out, clear_acc, accept, ovf, ovf_nxt;
    logic [AW-1:0] acc, acc_nxt, base;
    logic [AW:0]   sum;
    prod_accum_ctrl #(.N_TERMS(N_TERMS)) u_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .last_term (last_term),
        .load_out  (load_out),
        .clear_acc (clear_acc)
    );
    always_comb begin
        accept  = in_valid & in_ready & ~clr;
        base    = clear_acc ? '0 : acc;
        sum     = {1'b0, base} + {{(AW + 1 - PW){1'b0}}, in_prod};
`ifdef ACC_SAT_EN
        acc_nxt = sum[AW] ? '1 : sum[AW-1:0];
`else
        acc_nxt = sum[AW-1:0];
`endif
        ovf_nxt = (~clear_acc & ovf) | sum[AW];
    end
    // the last term goes straight to the output registers; acc restarts on the next group
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            ovf     <= 1'b0;
            out_sum <= '0;
            out_ovf <= 1'b0;
        end else begin
            if (clr) ovf <= 1'b0;
            else if (accept && !last_term) begin
                acc <= acc_nxt;
                ovf <= ovf_nxt;
            end
            if (load_out) begin
                out_sum <= acc_nxt;
                out_ovf <= ovf_nxt;
            end
        end
    end
endmodule

// File: tb/tb_prod_accum.sv
// tb_prod_accum: directed checks of prod_accum at AW=10 and AW=9 (wrap or ACC_SAT_EN clamp)
module tb_prod_accum;
    logic       clk = 0, rst_n = 0, clr = 0, in_valid = 0, out_ready = 0;
    logic [7:0] in_prod = '0;
    logic       in_ready, out_valid, out_ovf;
    logic [9:0] out_sum;
    logic       in_ready9, out_valid9, out_ovf9;
    logic [8:0] out_sum9;
    int tests = 0, fails = 0;
`ifdef ACC_SAT_EN
    localparam int EXP9 = 511;
`else
    localparam int EXP9 = 388;
`endif
    always #5 clk = ~clk;
    prod_accum dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .in_prod(in_prod), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_ovf(out_ovf)
    );
    prod_accum #(.AW(9)) dut9 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready9),
        .in_prod(in_prod), .out_valid(out_valid9), .out_ready(out_ready),
        .out_sum(out_sum9), .out_ovf(out_ovf9)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic send(input logic [7:0] p);
        in_valid = 1;
        in_prod  = p;
        tick();
    endtask
    task automatic idle();
        in_valid = 0;
        in_prod  = 'x;
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end
    initial begin
        automatic logic [7:0] gvals[4] = '{8'd3, 8'd0, 8'd9, 8'd4};
        tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_out_ovf", out_ovf, 0);
        rst_n = 1;
        tick();
        // reset in the middle of a group
        out_ready = 1;
        send(5);
        send(7);
        idle();
        rst_n = 0;
        #2;
        chk("t1_rst_valid", out_valid, 0);
        chk("t1_rst_ready", in_ready, 1);
        rst_n = 1;
        tick();
        send(1); send(2); send(3); send(4);
        idle();
        chk("t1_valid", out_valid, 1);
        chk("t1_sum", out_sum, 10);
        tick();
        chk("t1_release", out_valid, 0);
        // back-to-back maximum products
        send(225); send(225); send(225);
        chk("t2_early", out_valid, 0);
        send(225);
        idle();
        chk("t2_valid", out_valid, 1);
        chk("t2_sum", out_sum, 900);
        chk("t2_ovf", out_ovf, 0);
        chk("t6_sum9", out_sum9, EXP9);
        chk("t6_ovf9", out_ovf9, 1);
        tick();
        chk("t2_release", out_valid, 0);
        // backpressure, with a product waiting that must not slip in early
        out_ready = 0;
        send(6); send(10); send(15); send(1);
        chk("t3_sum", out_sum, 32);
        chk("t3_sum9", out_sum9, 32);
        chk("t3_ovf9_cleared", out_ovf9, 0);
        in_valid = 1;
        in_prod  = 50;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_hold_valid", out_valid, 1);
            chk("t3_hold_sum", out_sum, 32);
            chk("t3_hold_ready", in_ready, 0);
        end
        out_ready = 1;
        tick();
        chk("t3_exit_valid", out_valid, 0);
        chk("t3_exit_ready", in_ready, 1);
        tick(); tick(); tick();
        chk("t3_nobypass", out_valid, 0);
        tick();
        idle();
        chk("t3_next_valid", out_valid, 1);
        chk("t3_next_sum", out_sum, 200);
        tick();
        // gapped input with X on in_prod while idle
        for (int i = 0; i < 4; i++) begin
            idle();
            repeat ($urandom_range(0, 3)) begin
                tick();
                chk("t4_gap_valid", out_valid, 0);
            end
            send(gvals[i]);
        end
        idle();
        chk("t4_valid", out_valid, 1);
        chk("t4_sum", out_sum, 16);
        tick();
        // clr mid-group drops partial sum, overflow flag and the presented product
        send(225); send(225); send(225);
        clr      = 1;
        in_valid = 1;
        in_prod  = 100;
        tick();
        clr = 0;
        chk("t5_clr_valid", out_valid, 0);
        chk("t5_clr_ready", in_ready, 1);
        out_ready = 0;
        send(1); send(1); send(1);
        chk("t5_early", out_valid, 0);
        send(1);
        idle();
        chk("t5_valid", out_valid, 1);
        chk("t5_sum", out_sum, 4);
        chk("t5_sum9", out_sum9, 4);
        chk("t5_ovf9", out_ovf9, 0);
        // clr while holding discards the result
        clr = 1;
        tick();
        clr = 0;
        chk("t5_hold_clr_valid", out_valid, 0);
        chk("t5_hold_clr_ready", in_ready, 1);
        out_ready = 1;
        send(2); send(2); send(2); send(2);
        idle();
        chk("t5_after_valid", out_valid, 1);
        chk("t5_after_sum", out_sum, 8);
        tick();
        chk("t5_after_release", out_valid, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
